// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the FIFO push arbiter.
//   - arb_state_e : two-state arbiter FSM encoding (IDLE, GRANT)
//   - MAX_N_REQ / MAX_BURST : supported parameter ceilings
//   - idx_width() / cnt_width() : width helpers for owner index and beat counter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_N_REQ = 8;
  localparam int unsigned MAX_BURST = 16;

  // Index width for a requester vector; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter must be able to hold the value BURST itself.
  function automatic int unsigned cnt_width(input int unsigned burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin search. Starting at last_idx_i+1 and wrapping,
//   the first asserted request wins.
//   Ports:
//     req_i      [N_REQ]  request vector
//     last_idx_i [IDX_W]  index of the previous winner
//     gnt_o      [N_REQ]  one-hot winner (zero when no request)
//     gnt_idx_o  [IDX_W]  winner index (zero when no request)
//     any_o               at least one request present
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_idx_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  // cand_idx[k] is the requester examined at search distance k+1.
  logic [IDX_W-1:0] cand_idx [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    always_comb begin
      int s;
      s = int'(last_idx_i) + gi + 1;
      // last_idx_i < N_REQ, so one subtraction is enough to wrap.
      if (s >= int'(N_REQ)) begin
        s = s - int'(N_REQ);
      end
      cand_idx[gi] = IDX_W'(s);
    end
  end

  // Walk from the farthest candidate to the nearest so the nearest
  // asserted request is the last one written and therefore wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[cand_idx[i]]) begin
        gnt_idx_o = cand_idx[i];
        any_o     = 1'b1;
      end
    end
    if (any_o) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Arbitrates N_REQ burst sources onto the push side of a synchronous FIFO.
//   A round-robin winner owns the FIFO for up to BURST beats, or until it
//   drops valid, then one IDLE cycle separates it from the next grant.
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous reset, active low
//     req_valid_i  [N_REQ]         per-requester beat valid
//     req_data_i   [N_REQ*DATA_W]  packed data, requester i at [i*DATA_W +: DATA_W]
//     req_ready_o  [N_REQ]         per-requester ready (at most one high)
//     push_o                       FIFO push strobe (same cycle as the handshake)
//     push_data_o  [DATA_W]        FIFO write data (owner slice, zero when idle)
//     full_i                       FIFO full flag; stalls the owner
//     grant_o      [N_REQ]         one-hot registered owner, zero when idle
//     busy_o                       high while a grant is active
//   N_REQ is 2..8, BURST is 1..16.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BURST  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic                      push_o,
  output logic [DATA_W-1:0]         push_data_o,
  input  logic                      full_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      busy_o
);

  localparam int unsigned      IDX_W     = idx_width(N_REQ);
  localparam int unsigned      CNT_W     = cnt_width(BURST);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST);
  // Pointing at the last requester makes requester 0 win first after reset.
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  logic [DATA_W-1:0] data_arr [N_REQ];
  logic [DATA_W-1:0] owner_data;
  logic              owner_valid;
  logic              in_grant;
  logic              xfer;
  logic [CNT_W-1:0]  cnt_inc;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i      (req_valid_i),
    .last_idx_i (last_owner_q),
    .gnt_o      (arb_gnt),
    .gnt_idx_o  (arb_idx),
    .any_o      (arb_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      cnt_q        <= '0;
      grant_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
    end
  end

  // Outputs are decoded from registered state, so asserting reset forces
  // them all to zero immediately without waiting for a clock edge.
  always_comb begin
    in_grant    = (state_q == GRANT);
    owner_valid = req_valid_i[owner_q];
    owner_data  = data_arr[owner_q];
    // full_i gates the handshake, so push_o can never coincide with full.
    xfer        = in_grant && owner_valid && !full_i;
    cnt_inc     = cnt_q + CNT_W'(1);

    req_ready_o = '0;
    if (in_grant) begin
      req_ready_o[owner_q] = !full_i;
    end
    push_o      = xfer;
    push_data_o = in_grant ? owner_data : '0;
    grant_o     = grant_q;
    busy_o      = in_grant;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = GRANT;
          owner_d = arb_idx;
          grant_d = arb_gnt;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // A stalled owner (full_i) keeps its count; only a valid drop or
        // the final beat releases the grant.
        if (xfer) begin
          cnt_d = cnt_inc;
        end
        if ((xfer && (cnt_inc == BURST_CNT)) || !owner_valid) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          grant_d      = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_push_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            push_o;
  logic [DW-1:0]   push_data_o;
  logic            full_i = 1'b0;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  fifo_push_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST(BURST)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .push_o      (push_o),
    .push_data_o (push_data_o),
    .full_i      (full_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  grant;
    logic [N-1:0]  ready;
    logic          busy;
    logic          push;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] data_q[$];
  int            errors = 0;
  int            checks = 0;

  // Reference model: who owns the FIFO, beats taken, previous owner.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_cnt;
  int seq[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] src_word(input int i);
    return DW'((i << 5) | (seq[i] % 32));
  endfunction

  // One clock cycle of stimulus; expected outputs for that cycle are queued.
  task automatic cycle(input logic [N-1:0] v, input logic f, input bit rst_on);
    exp_t e;
    bit   xfer;
    @(posedge clk);
    #1;
    req_valid_i = v;
    full_i      = f;
    reset       = !rst_on;
    for (int i = 0; i < N; i++) req_data_i[i*DW +: DW] = src_word(i);
    if (rst_on) begin
      m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
      e.grant = '0; e.ready = '0; e.busy = 0; e.push = 0; e.data = '0;
      exp_q.push_back(e);
      #1;
      chk("rst_push", push_o, 0);
      chk("rst_outputs", {grant_o, req_ready_o, busy_o, push_data_o}, 0);
    end else begin
      xfer    = m_busy && v[m_owner] && !f;
      e.busy  = m_busy;
      e.grant = m_busy ? (N'(1) << m_owner) : '0;
      e.ready = (m_busy && !f) ? (N'(1) << m_owner) : '0;
      e.push  = xfer;
      e.data  = m_busy ? src_word(m_owner) : '0;
      exp_q.push_back(e);
      if (xfer) data_q.push_back(src_word(m_owner));
      if (!m_busy) begin
        if (v != 0) begin
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (v[c]) begin m_owner = c; break; end
          end
          m_busy = 1;
          m_cnt  = 0;
        end
      end else begin
        if (xfer) begin
          seq[m_owner]++;
          m_cnt++;
        end
        if ((xfer && m_cnt == BURST) || !v[m_owner]) begin
          m_busy = 0;
          m_last = m_owner;
        end
      end
    end
  endtask

  // Monitor: compares every presented cycle and pops push data on push_o.
  initial begin
    exp_t e;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_o", grant_o, e.grant);
        chk("req_ready_o", req_ready_o, e.ready);
        chk("busy_o", busy_o, e.busy);
        chk("push_o", push_o, e.push);
        chk("push_data_o", push_data_o, e.data);
        chk("ready_onehot", ($countones(req_ready_o) <= 1), 1);
        chk("push_vs_full", (push_o && full_i), 0);
        if (push_o) begin
          if (data_q.size() == 0) begin
            chk("push_unexpected", 1, 0);
          end else begin
            d = data_q.pop_front();
            chk("push_order", push_data_o, d);
          end
        end
      end
    end
  end

  initial begin
    bit           found;
    logic [N-1:0] v;
    logic         f;
    for (int i = 0; i < N; i++) seq[i] = 0;

    // Reset, then a lone requester 0.
    for (int k = 0; k < 3; k++) cycle('0, 0, 1);
    cycle(4'b0001, 0, 0);
    cycle(4'b0001, 0, 0);
    chk("first_grant", grant_o, 4'b0001);
    for (int k = 0; k < 10; k++) cycle(4'b0001, 0, 0);

    // All requesters continuously valid.
    for (int k = 0; k < 25; k++) cycle(4'hF, 0, 0);

    // Owner 2 drops valid after two beats; requester 3 is next.
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_busy && m_owner == 2 && m_cnt == 2) begin
        cycle(4'b1011, 0, 0);
        found = 1;
      end else begin
        cycle(4'hF, 0, 0);
      end
    end
    chk("owner2_drop_reached", found, 1);
    cycle(4'hF, 0, 0);
    cycle(4'hF, 0, 0);
    chk("grant_after_drop", grant_o, 4'b1000);

    // FIFO full for five cycles mid-burst.
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_busy && m_cnt == 2) begin
        for (int j = 0; j < 5; j++) cycle(4'hF, 1, 0);
        found = 1;
      end else begin
        cycle(4'hF, 0, 0);
      end
    end
    chk("full_stall_reached", found, 1);
    for (int k = 0; k < 8; k++) cycle(4'hF, 0, 0);

    // Reset during the third beat of a burst.
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_busy && m_cnt == 2) begin
        cycle(4'hF, 0, 1);
        found = 1;
      end else begin
        cycle(4'hF, 0, 0);
      end
    end
    chk("midburst_reset_reached", found, 1);
    cycle(4'hF, 0, 1);
    cycle(4'hF, 0, 0);
    cycle(4'hF, 0, 0);
    chk("grant_after_reset", grant_o, 4'b0001);
    for (int k = 0; k < 10; k++) cycle(4'hF, 0, 0);

    // Random valids and full.
    v = '0;
    for (int k = 0; k < 8000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
      end
      f = ($urandom_range(0, 4) == 0);
      cycle(v, f, 0);
    end

    cycle('0, 0, 0);
    cycle('0, 0, 0);
    @(negedge clk);
    #1;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("data_queue_drained", data_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
